// File: rtl/river_crossing_pkg.sv
// rtl/river_crossing_pkg.sv - shared types for the river crossing engine
//
// Purpose: result-code and FSM-state enumerations used by the engine top
//          and its legality checker.
// Ports:   none (package).
package river_crossing_pkg;

  typedef enum logic [2:0] {
    RSP_OK         = 3'd0,
    RSP_EMPTY_BOAT = 3'd1,
    RSP_OVER_CAP   = 3'd2,
    RSP_NOT_AVAIL  = 3'd3,
    RSP_UNSAFE     = 3'd4,
    RSP_GAME_OVER  = 3'd5,
    RSP_NO_UNDO    = 3'd6
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/river_crossing_engine_if.sv
// rtl/river_crossing_engine_if.sv - request/response bundle of the river crossing engine
//
// Purpose: groups the move request handshake and the one-cycle result pulse.
// Signals: mv_valid/mv_ready/mv_undo/mv_m/mv_c  request from the front end
//          rsp_valid/rsp_code                    result back to the front end
// Modports: master = front end, slave = engine.
interface river_crossing_engine_if #(
  parameter int MW = 2,
  parameter int CW = 2
);

  logic          mv_valid;
  logic          mv_ready;
  logic          mv_undo;
  logic [MW-1:0] mv_m;
  logic [CW-1:0] mv_c;
  logic          rsp_valid;
  logic [2:0]    rsp_code;

  modport master (
    output mv_valid, mv_undo, mv_m, mv_c,
    input  mv_ready, rsp_valid, rsp_code
  );

  modport slave (
    input  mv_valid, mv_undo, mv_m, mv_c,
    output mv_ready, rsp_valid, rsp_code
  );

endinterface

// File: rtl/river_crossing_engine_checker.sv
// rtl/river_crossing_engine_checker.sv - combinational legality check for one request
//
// Purpose: given the current game state, the undo history and a latched
//          request, produce the result code and the state that would be
//          committed on success.
// Ports:   left_m_i/left_c_i/boat_side_i/done_i   current game state
//          hist_*_i                               one-deep undo history
//          req_undo_i/req_m_i/req_c_i             latched request
//          code_o                                 result code
//          nxt_m_o/nxt_c_o/nxt_side_o             state to commit when code_o is OK
module river_crossing_checker
  import river_crossing_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int NUM_C = 3,
  parameter int CAP   = 2,
  localparam int MW = $clog2(NUM_M + 1),
  localparam int CW = $clog2(NUM_C + 1),
  localparam int SW = ((MW > CW) ? MW : CW) + 1
) (
  input  logic          [MW-1:0] left_m_i,
  input  logic          [CW-1:0] left_c_i,
  input  logic                   boat_side_i,
  input  logic                   done_i,
  input  logic                   hist_valid_i,
  input  logic          [MW-1:0] hist_m_i,
  input  logic          [CW-1:0] hist_c_i,
  input  logic                   hist_side_i,
  input  logic                   req_undo_i,
  input  logic          [MW-1:0] req_m_i,
  input  logic          [CW-1:0] req_c_i,
  output rsp_code_e              code_o,
  output logic          [MW-1:0] nxt_m_o,
  output logic          [CW-1:0] nxt_c_o,
  output logic                   nxt_side_o
);

  // Everything is widened to SW bits so sums and bank differences never wrap.
  logic [SW-1:0] lm, lc, rm, rc, qm, qc, sum, src_m, src_c;
  logic [SW-1:0] nlm, nlc, nrm, nrc;
  logic          avail, unsafe;

  always_comb begin
    lm    = SW'(left_m_i);
    lc    = SW'(left_c_i);
    rm    = SW'(NUM_M) - lm;
    rc    = SW'(NUM_C) - lc;
    qm    = SW'(req_m_i);
    qc    = SW'(req_c_i);
    sum   = qm + qc;
    src_m = boat_side_i ? rm : lm;
    src_c = boat_side_i ? rc : lc;
    avail = (qm <= src_m) && (qc <= src_c);
    // Post-move banks; only meaningful once availability holds.
    nlm   = boat_side_i ? (lm + qm) : (lm - qm);
    nlc   = boat_side_i ? (lc + qc) : (lc - qc);
    nrm   = SW'(NUM_M) - nlm;
    nrc   = SW'(NUM_C) - nlc;
    unsafe = ((nlm != '0) && (nlm < nlc)) || ((nrm != '0) && (nrm < nrc));
  end

  always_comb begin
    code_o     = RSP_OK;
    nxt_m_o    = left_m_i;
    nxt_c_o    = left_c_i;
    nxt_side_o = boat_side_i;
    if (req_undo_i) begin
      if (hist_valid_i) begin
        nxt_m_o    = hist_m_i;
        nxt_c_o    = hist_c_i;
        nxt_side_o = hist_side_i;
      end else begin
        code_o = RSP_NO_UNDO;
      end
    end else if (done_i) begin
      code_o = RSP_GAME_OVER;
    end else if (sum == '0) begin
      code_o = RSP_EMPTY_BOAT;
    end else if (32'(sum) > 32'(CAP)) begin
      code_o = RSP_OVER_CAP;
    end else if (!avail) begin
      code_o = RSP_NOT_AVAIL;
    end else if (unsafe) begin
      code_o = RSP_UNSAFE;
    end else begin
      nxt_m_o    = nlm[MW-1:0];
      nxt_c_o    = nlc[CW-1:0];
      nxt_side_o = ~boat_side_i;
    end
  end

endmodule

// File: rtl/river_crossing_engine.sv
// rtl/river_crossing_engine.sv - interactive missionaries-and-cannibals game engine
//
// Purpose: holds bank/boat state, accepts one move or undo per three cycles,
//          checks it, commits legal moves and reports a result code.
// Ports:   CLK        clock, rising edge
//          RST        asynchronous active-low reset
//          clear      synchronous restart to the initial position
//          bus        request/response bundle (slave side)
//          left_m/left_c/boat_side  game state
//          move_cnt   saturating committed-move count
//          done       everyone is on the right bank
module river_crossing_engine
  import river_crossing_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int NUM_C = 3,
  parameter int CAP   = 2,
  parameter int CNT_W = 8,
  localparam int MW = $clog2(NUM_M + 1),
  localparam int CW = $clog2(NUM_C + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  river_crossing_engine_if.slave bus,
  output logic [MW-1:0]        left_m,
  output logic [CW-1:0]        left_c,
  output logic                 boat_side,
  output logic [CNT_W-1:0]     move_cnt,
  output logic                 done
);

  fsm_state_e       state_q, state_d;
  logic             req_undo_q, req_undo_d;
  logic [MW-1:0]    req_m_q, req_m_d;
  logic [CW-1:0]    req_c_q, req_c_d;
  rsp_code_e        code_q, code_d;
  logic [MW-1:0]    left_m_q, left_m_d;
  logic [CW-1:0]    left_c_q, left_c_d;
  logic             side_q, side_d;
  logic [MW-1:0]    hist_m_q, hist_m_d;
  logic [CW-1:0]    hist_c_q, hist_c_d;
  logic             hist_side_q, hist_side_d;
  logic             hist_valid_q, hist_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  rsp_code_e        chk_code;
  logic [MW-1:0]    chk_m;
  logic [CW-1:0]    chk_c;
  logic             chk_side;

  river_crossing_checker #(
    .NUM_M(NUM_M),
    .NUM_C(NUM_C),
    .CAP  (CAP)
  ) u_checker (
    .left_m_i    (left_m_q),
    .left_c_i    (left_c_q),
    .boat_side_i (side_q),
    .done_i      (done_q),
    .hist_valid_i(hist_valid_q),
    .hist_m_i    (hist_m_q),
    .hist_c_i    (hist_c_q),
    .hist_side_i (hist_side_q),
    .req_undo_i  (req_undo_q),
    .req_m_i     (req_m_q),
    .req_c_i     (req_c_q),
    .code_o      (chk_code),
    .nxt_m_o     (chk_m),
    .nxt_c_o     (chk_c),
    .nxt_side_o  (chk_side)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; clear overrides everything, including a pending accept
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.mv_valid) state_d = ST_CHECK;
        ST_CHECK:  state_d = ST_COMMIT;
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    bus.mv_ready  = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_COMMIT);
    bus.rsp_code  = (state_q == ST_COMMIT) ? 3'(code_q) : 3'd0;
  end

  // Datapath next state. The commit happens on the CHECK->COMMIT edge so the
  // new position is already visible while the response pulse is high.
  always_comb begin
    req_undo_d   = req_undo_q;
    req_m_d      = req_m_q;
    req_c_d      = req_c_q;
    code_d       = code_q;
    left_m_d     = left_m_q;
    left_c_d     = left_c_q;
    side_d       = side_q;
    hist_m_d     = hist_m_q;
    hist_c_d     = hist_c_q;
    hist_side_d  = hist_side_q;
    hist_valid_d = hist_valid_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    if (clear) begin
      code_d       = RSP_OK;
      left_m_d     = MW'(NUM_M);
      left_c_d     = CW'(NUM_C);
      side_d       = 1'b0;
      hist_valid_d = 1'b0;
      cnt_d        = '0;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mv_valid) begin
            req_undo_d = bus.mv_undo;
            req_m_d    = bus.mv_m;
            req_c_d    = bus.mv_c;
          end
        end
        ST_CHECK: begin
          code_d = chk_code;
          if (chk_code == RSP_OK) begin
            left_m_d = chk_m;
            left_c_d = chk_c;
            side_d   = chk_side;
            done_d   = (chk_m == '0) && (chk_c == '0) && chk_side;
            if (req_undo_q) begin
              hist_valid_d = 1'b0;
              if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end else begin
              hist_m_d     = left_m_q;
              hist_c_d     = left_c_q;
              hist_side_d  = side_q;
              hist_valid_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_undo_q   <= 1'b0;
      req_m_q      <= '0;
      req_c_q      <= '0;
      code_q       <= RSP_OK;
      left_m_q     <= MW'(NUM_M);
      left_c_q     <= CW'(NUM_C);
      side_q       <= 1'b0;
      hist_m_q     <= '0;
      hist_c_q     <= '0;
      hist_side_q  <= 1'b0;
      hist_valid_q <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      req_undo_q   <= req_undo_d;
      req_m_q      <= req_m_d;
      req_c_q      <= req_c_d;
      code_q       <= code_d;
      left_m_q     <= left_m_d;
      left_c_q     <= left_c_d;
      side_q       <= side_d;
      hist_m_q     <= hist_m_d;
      hist_c_q     <= hist_c_d;
      hist_side_q  <= hist_side_d;
      hist_valid_q <= hist_valid_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  assign left_m    = left_m_q;
  assign left_c    = left_c_q;
  assign boat_side = side_q;
  assign move_cnt  = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_river_crossing_engine.sv
// tb/tb_river_crossing_engine.sv - directed self-checking bench for river_crossing_engine
module tb_river_crossing_engine;

  logic CLK = 1'b0;
  logic rst_n;
  logic clear_a, clear_b;

  always #5 CLK = ~CLK;

  river_crossing_engine_if #(.MW(2), .CW(2)) bus_a ();
  river_crossing_engine_if #(.MW(3), .CW(3)) bus_b ();

  logic [1:0] a_lm, a_lc;
  logic       a_side, a_done;
  logic [7:0] a_cnt;
  logic [2:0] b_lm, b_lc;
  logic       b_side, b_done;
  logic [1:0] b_cnt;

  river_crossing_engine #(.NUM_M(3), .NUM_C(3), .CAP(2), .CNT_W(8)) dut_a (
    .CLK(CLK), .RST(rst_n), .clear(clear_a), .bus(bus_a),
    .left_m(a_lm), .left_c(a_lc), .boat_side(a_side), .move_cnt(a_cnt), .done(a_done)
  );

  river_crossing_engine #(.NUM_M(4), .NUM_C(4), .CAP(3), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(rst_n), .clear(clear_b), .bus(bus_b),
    .left_m(b_lm), .left_c(b_lc), .boat_side(b_side), .move_cnt(b_cnt), .done(b_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request on bus_a; returns the response code (-1 on timeout) and the
  // number of edges from acceptance to the response pulse.
  task automatic move_a(input bit undo, input int m, input int c, output int code, output int lat);
    @(negedge CLK);
    bus_a.mv_valid = 1'b1;
    bus_a.mv_undo  = undo;
    bus_a.mv_m     = 2'(m);
    bus_a.mv_c     = 2'(c);
    @(posedge CLK); #1;
    bus_a.mv_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 6) begin
      @(posedge CLK); #1;
      lat++;
    end
    code = bus_a.rsp_valid ? int'(bus_a.rsp_code) : -1;
    @(posedge CLK); #1;
  endtask

  task automatic move_b(input bit undo, input int m, input int c, output int code);
    int lat;
    @(negedge CLK);
    bus_b.mv_valid = 1'b1;
    bus_b.mv_undo  = undo;
    bus_b.mv_m     = 3'(m);
    bus_b.mv_c     = 3'(c);
    @(posedge CLK); #1;
    bus_b.mv_valid = 1'b0;
    lat = 1;
    while (!bus_b.rsp_valid && lat < 6) begin
      @(posedge CLK); #1;
      lat++;
    end
    code = bus_b.rsp_valid ? int'(bus_b.rsp_code) : -1;
    @(posedge CLK); #1;
  endtask

  task automatic clear_pulse_a();
    @(negedge CLK); clear_a = 1'b1;
    @(negedge CLK); clear_a = 1'b0;
  endtask

  task automatic check_init_a(input string tag);
    check_eq({tag, "_lm"}, int'(a_lm), 3);
    check_eq({tag, "_lc"}, int'(a_lc), 3);
    check_eq({tag, "_side"}, int'(a_side), 0);
    check_eq({tag, "_cnt"}, int'(a_cnt), 0);
    check_eq({tag, "_done"}, int'(a_done), 0);
  endtask

  int cls_m [11] = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
  int cls_c [11] = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};
  int b_m   [9]  = '{0, 0, 0, 0, 3, 1, 2, 0, 0};
  int b_c   [9]  = '{3, 1, 2, 1, 0, 1, 0, 1, 3};

  initial begin
    int code, lat;
    rst_n = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    bus_a.mv_valid = 1'b0; bus_a.mv_undo = 1'b0; bus_a.mv_m = '0; bus_a.mv_c = '0;
    bus_b.mv_valid = 1'b0; bus_b.mv_undo = 1'b0; bus_b.mv_m = '0; bus_b.mv_c = '0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // Reset state
    check_init_a("rst");
    check_eq("rst_ready", int'(bus_a.mv_ready), 1);
    check_eq("rst_rsp_valid", int'(bus_a.rsp_valid), 0);
    check_eq("rst_rsp_code", int'(bus_a.rsp_code), 0);

    // Classic 11-move solution
    for (int i = 0; i < 11; i++) begin
      move_a(1'b0, cls_m[i], cls_c[i], code, lat);
      check_eq($sformatf("classic_%0d", i), code, 0);
      if (i == 0) check_eq("latency", lat, 2);
    end
    check_eq("classic_done", int'(a_done), 1);
    check_eq("classic_cnt", int'(a_cnt), 11);
    check_eq("classic_lm", int'(a_lm), 0);
    check_eq("classic_lc", int'(a_lc), 0);
    check_eq("classic_side", int'(a_side), 1);
    move_a(1'b0, 1, 0, code, lat);
    check_eq("game_over", code, 5);
    check_eq("game_over_cnt", int'(a_cnt), 11);

    // Undo from the finished position reopens the game
    move_a(1'b1, 0, 0, code, lat);
    check_eq("undo_done_code", code, 0);
    check_eq("undo_done_done", int'(a_done), 0);
    check_eq("undo_done_cnt", int'(a_cnt), 10);
    check_eq("undo_done_lc", int'(a_lc), 2);
    check_eq("undo_done_side", int'(a_side), 0);

    clear_pulse_a();
    check_init_a("clear");

    // Rejections from the initial position
    move_a(1'b0, 0, 0, code, lat);
    check_eq("empty_boat", code, 1);
    move_a(1'b0, 2, 1, code, lat);
    check_eq("over_cap", code, 2);
    move_a(1'b0, 1, 0, code, lat);
    check_eq("unsafe", code, 4);
    check_init_a("rejects");

    // Boat on the right with two cannibals
    move_a(1'b0, 0, 2, code, lat);
    check_eq("c2_ok", code, 0);
    move_a(1'b0, 1, 1, code, lat);
    check_eq("not_avail", code, 3);
    move_a(1'b0, 0, 3, code, lat);
    check_eq("over_cap_prio", code, 2);
    check_eq("not_avail_lc", int'(a_lc), 1);
    check_eq("not_avail_cnt", int'(a_cnt), 1);

    // Undo sequence
    clear_pulse_a();
    move_a(1'b1, 0, 0, code, lat);
    check_eq("undo_none", code, 6);
    move_a(1'b0, 0, 2, code, lat);
    check_eq("undo_pre", code, 0);
    move_a(1'b1, 0, 0, code, lat);
    check_eq("undo_ok", code, 0);
    check_init_a("undo");
    move_a(1'b1, 0, 0, code, lat);
    check_eq("undo_twice", code, 6);

    // clear during CHECK drops the in-flight request
    move_a(1'b0, 0, 2, code, lat);
    check_eq("clr_pre", code, 0);
    @(negedge CLK);
    bus_a.mv_valid = 1'b1; bus_a.mv_undo = 1'b0; bus_a.mv_m = 2'd0; bus_a.mv_c = 2'd1;
    @(posedge CLK); #1;
    bus_a.mv_valid = 1'b0;
    check_eq("clr_check_ready", int'(bus_a.mv_ready), 0);
    clear_a = 1'b1;
    @(posedge CLK); #1;
    clear_a = 1'b0;
    check_eq("clr_rsp_valid", int'(bus_a.rsp_valid), 0);
    check_eq("clr_ready", int'(bus_a.mv_ready), 1);
    check_init_a("clr");
    @(posedge CLK); #1;
    check_eq("clr_rsp_valid2", int'(bus_a.rsp_valid), 0);
    move_a(1'b1, 0, 0, code, lat);
    check_eq("clr_hist", code, 6);

    // Asynchronous reset during COMMIT
    move_a(1'b0, 0, 2, code, lat);
    check_eq("rst_pre", code, 0);
    @(negedge CLK);
    bus_a.mv_valid = 1'b1; bus_a.mv_undo = 1'b0; bus_a.mv_m = 2'd0; bus_a.mv_c = 2'd1;
    @(posedge CLK); #1;
    bus_a.mv_valid = 1'b0;
    @(posedge CLK); #1;
    check_eq("commit_rsp_valid", int'(bus_a.rsp_valid), 1);
    check_eq("commit_visible_lc", int'(a_lc), 2);
    rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid", int'(bus_a.rsp_valid), 0);
    check_eq("arst_rsp_code", int'(bus_a.rsp_code), 0);
    check_eq("arst_ready", int'(bus_a.mv_ready), 1);
    check_init_a("arst");
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // 4/4/3 instance with a 2-bit counter
    for (int i = 0; i < 9; i++) begin
      move_b(1'b0, b_m[i], b_c[i], code);
      check_eq($sformatf("b_move_%0d", i), code, 0);
      if (i == 4) check_eq("b_cnt_sat5", int'(b_cnt), 3);
    end
    check_eq("b_done", int'(b_done), 1);
    check_eq("b_cnt_final", int'(b_cnt), 3);
    check_eq("b_lm", int'(b_lm), 0);
    check_eq("b_lc", int'(b_lc), 0);
    check_eq("b_side", int'(b_side), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
